// File: rtl/mem_arbiter.sv
// Fixed-latency arbiter sharing one single-port memory between the I-fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ready,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_grant_d;
    logic        r_wr;
    logic        r_i_ready;
    logic        r_d_ready;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        r_mem_en;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_busy;
    logic        w_pick_d;

`ifdef MEM_ARB_RR_EN
    // r_last_d = 1 when D won the most recent grant; a tie goes to the other port
    logic r_last_d;
    always_comb w_pick_d = d_req & (~i_req | ~r_last_d);
`else
    always_comb w_pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_grant_d   <= 1'b0;
            r_wr        <= 1'b0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_wr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        r_state    <= S_ACCESS;
                        r_busy     <= 1'b1;
                        r_grant_d  <= w_pick_d;
                        r_wr       <= w_pick_d & d_wr;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= w_pick_d & d_wr;
                        r_mem_addr <= w_pick_d ? d_addr : i_addr;
                        if (w_pick_d) begin
                            r_mem_wdata <= d_wdata;
                        end
`ifdef MEM_ARB_RR_EN
                        r_last_d   <= w_pick_d;
`endif
                    end
                end
                S_ACCESS: begin
                    r_cnt   <= LAT_M1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_wr) begin
                            if (r_grant_d) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        if (r_grant_d) begin
                            r_d_ready <= 1'b1;
                        end else begin
                            r_i_ready <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ready   = r_i_ready;
    assign i_rdata   = r_i_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses LATENCY=4, instance 1 uses LATENCY=1.
// Expectations follow MEM_ARB_RR_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_mem_arbiter;
    typedef struct {
        int          cyc;
        logic        is_d;
        logic [15:0] data;
    } rdy_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic        rst_n   [2];
    logic        i_req   [2];
    logic        d_req   [2];
    logic        d_wr    [2];
    logic [15:0] i_addr  [2];
    logic [15:0] d_addr  [2];
    logic [15:0] d_wdata [2];
    logic        i_ready [2];
    logic        d_ready [2];
    logic        mem_en  [2];
    logic        mem_wr  [2];
    logic        busy    [2];
    logic [15:0] i_rdata [2];
    logic [15:0] d_rdata [2];
    logic [15:0] mem_addr[2];
    logic [15:0] mem_wdata[2];

    rdy_t rq[2][$];
    acc_t aq[2][$];
    logic [15:0] mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, cycle %0d): got %0h, expected %0h", name, p, cyc, act, exp);
        end
    endtask

    task automatic exp_acc(input int p, input int c, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        acc_t a;
        a.cyc = c; a.wr = wr; a.addr = addr; a.wdata = wdata;
        aq[p].push_back(a);
    endtask

    task automatic exp_rdy(input int p, input int c, input logic is_d, input logic [15:0] data);
        rdy_t r;
        r.cyc = c; r.is_d = is_d; r.data = data;
        rq[p].push_back(r);
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset(input int p);
        rst_n[p] = 1'b0;
        i_req[p] = 1'b0;
        d_req[p] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[p] = 1'b1;
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'hDEAD;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 4 : 1;
        logic [15:0] r_mrd = 16'hDEAD;
        logic        pend = 1'b0;
        int          pend_due = 0;
        logic [15:0] pend_data = 16'h0000;

        mem_arbiter #(.LATENCY(LAT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .i_req     (i_req[g]),
            .i_addr    (i_addr[g]),
            .i_ready   (i_ready[g]),
            .i_rdata   (i_rdata[g]),
            .d_req     (d_req[g]),
            .d_wr      (d_wr[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_ready   (d_ready[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_wr    (mem_wr[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (r_mrd),
            .busy      (busy[g])
        );

        // Memory model plus monitor; read data is only valid in its due cycle
        always @(negedge clk) begin
            acc_t a;
            rdy_t r;
            if (pend && pend_due == cyc) begin
                r_mrd = pend_data;
                pend  = 1'b0;
            end else begin
                r_mrd = 16'hDEAD;
            end
            if (mem_en[g] === 1'b1) begin
                if (aq[g].size() == 0) begin
                    chk("unexpected mem_en", g, 32'(mem_addr[g]), 32'hFFFFFFFF);
                end else begin
                    a = aq[g].pop_front();
                    chk("mem_en cycle", g, 32'(cyc), 32'(a.cyc));
                    chk("mem_wr", g, 32'(mem_wr[g]), 32'(a.wr));
                    chk("mem_addr", g, 32'(mem_addr[g]), 32'(a.addr));
                    if (a.wr) chk("mem_wdata", g, 32'(mem_wdata[g]), 32'(a.wdata));
                end
                if (mem_wr[g] === 1'b1) begin
                    mem[int'(mem_addr[g])] = mem_wdata[g];
                end else begin
                    pend      = 1'b1;
                    pend_due  = cyc + int'(LAT);
                    pend_data = mem_rd(mem_addr[g]);
                end
            end
            if (i_ready[g] === 1'b1 || d_ready[g] === 1'b1) begin
                if (rq[g].size() == 0) begin
                    chk("unexpected ready", g, {30'd0, i_ready[g], d_ready[g]}, 32'd0);
                end else begin
                    r = rq[g].pop_front();
                    chk("ready cycle", g, 32'(cyc), 32'(r.cyc));
                    chk("i_ready", g, 32'(i_ready[g]), 32'(!r.is_d));
                    chk("d_ready", g, 32'(d_ready[g]), 32'(r.is_d));
                    chk(r.is_d ? "d_rdata" : "i_rdata", g,
                        32'(r.is_d ? d_rdata[g] : i_rdata[g]), 32'(r.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   c0;
        logic is_d;
        for (int p = 0; p < 2; p++) begin
            rst_n[p] = 1'b0; i_req[p] = 1'b0; d_req[p] = 1'b0; d_wr[p] = 1'b0;
            i_addr[p] = '0; d_addr[p] = '0; d_wdata[p] = '0;
        end
        mem[32'h0010] = 16'hBEEF;
        mem[32'h0000] = 16'h1111;
        mem[32'h0001] = 16'h2222;
        mem[32'h0100] = 16'hA5A5;
        mem[32'h0300] = 16'h5A5A;
        mem[32'h0040] = 16'h7777;
        mem[32'h0200] = 16'h0BAD;

        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk("reset mem_en", p, 32'(mem_en[p]), 0);
            chk("reset mem_wr", p, 32'(mem_wr[p]), 0);
            chk("reset i_ready", p, 32'(i_ready[p]), 0);
            chk("reset d_ready", p, 32'(d_ready[p]), 0);
            chk("reset busy", p, 32'(busy[p]), 0);
            chk("reset mem_addr", p, 32'(mem_addr[p]), 0);
            chk("reset mem_wdata", p, 32'(mem_wdata[p]), 0);
            chk("reset i_rdata", p, 32'(i_rdata[p]), 0);
            chk("reset d_rdata", p, 32'(d_rdata[p]), 0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // I read of 0x0010
        c0 = cyc;
        i_addr[0] = 16'h0010; i_req[0] = 1'b1;
        exp_acc(0, c0 + 1, 1'b0, 16'h0010, 16'h0000);
        exp_rdy(0, c0 + 6, 1'b0, 16'hBEEF);
        wait_until(c0 + 6); i_req[0] = 1'b0;
        wait_until(c0 + 8);

        // D write, then read back the written word
        do_reset(0);
        c0 = cyc;
        d_wr[0] = 1'b1; d_addr[0] = 16'h0200; d_wdata[0] = 16'h1234; d_req[0] = 1'b1;
        exp_acc(0, c0 + 1, 1'b1, 16'h0200, 16'h1234);
        exp_rdy(0, c0 + 6, 1'b1, 16'h0000);
        wait_until(c0 + 6); d_req[0] = 1'b0;
        wait_until(c0 + 7);
        c0 = cyc;
        d_wr[0] = 1'b0; d_req[0] = 1'b1;
        exp_acc(0, c0 + 1, 1'b0, 16'h0200, 16'h0000);
        exp_rdy(0, c0 + 6, 1'b1, 16'h1234);
        wait_until(c0 + 6); d_req[0] = 1'b0;
        wait_until(c0 + 8);

        // Simultaneous requests: D first, I after
        do_reset(0);
        c0 = cyc;
        i_addr[0] = 16'h0010; d_addr[0] = 16'h0300; d_wr[0] = 1'b0;
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        exp_acc(0, c0 + 1, 1'b0, 16'h0300, 16'h0000);
        exp_rdy(0, c0 + 6, 1'b1, 16'h5A5A);
        exp_acc(0, c0 + 8, 1'b0, 16'h0010, 16'h0000);
        exp_rdy(0, c0 + 13, 1'b0, 16'hBEEF);
        wait_until(c0 + 6); d_req[0] = 1'b0;
        wait_until(c0 + 13); i_req[0] = 1'b0;
        wait_until(c0 + 15);

        // Both held for four completions
        do_reset(0);
        c0 = cyc;
        i_addr[0] = 16'h0100; d_addr[0] = 16'h0300; d_wr[0] = 1'b0;
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            is_d = (k % 2 == 0);
`else
            is_d = 1'b1;
`endif
            exp_acc(0, c0 + 1 + 7 * k, 1'b0, is_d ? 16'h0300 : 16'h0100, 16'h0000);
            exp_rdy(0, c0 + 6 + 7 * k, is_d, is_d ? 16'h5A5A : 16'hA5A5);
        end
        wait_until(c0 + 27); i_req[0] = 1'b0; d_req[0] = 1'b0;
        wait_until(c0 + 29);

        // Reset in cycle 3 of an I read, then a normal read
        do_reset(0);
        c0 = cyc;
        i_addr[0] = 16'h0040; i_req[0] = 1'b1;
        exp_acc(0, c0 + 1, 1'b0, 16'h0040, 16'h0000);
        wait_until(c0 + 3); rst_n[0] = 1'b0; i_req[0] = 1'b0;
        wait_until(c0 + 4); rst_n[0] = 1'b1;
        chk("busy after mid reset", 0, 32'(busy[0]), 0);
        chk("mem_en after mid reset", 0, 32'(mem_en[0]), 0);
        chk("i_ready after mid reset", 0, 32'(i_ready[0]), 0);
        wait_until(c0 + 6);
        c0 = cyc;
        i_addr[0] = 16'h0010; i_req[0] = 1'b1;
        exp_acc(0, c0 + 1, 1'b0, 16'h0010, 16'h0000);
        exp_rdy(0, c0 + 6, 1'b0, 16'hBEEF);
        wait_until(c0 + 6); i_req[0] = 1'b0;
        wait_until(c0 + 8);

        // LATENCY=1: back-to-back I reads with req held across ready
        do_reset(1);
        c0 = cyc;
        i_addr[1] = 16'h0000; i_req[1] = 1'b1;
        exp_acc(1, c0 + 1, 1'b0, 16'h0000, 16'h0000);
        exp_rdy(1, c0 + 3, 1'b0, 16'h1111);
        exp_acc(1, c0 + 5, 1'b0, 16'h0001, 16'h0000);
        exp_rdy(1, c0 + 7, 1'b0, 16'h2222);
        wait_until(c0 + 3); i_addr[1] = 16'h0001;
        wait_until(c0 + 7); i_req[1] = 1'b0;
        wait_until(c0 + 12);

        for (int p = 0; p < 2; p++) begin
            chk("ready queue drained", p, 32'(rq[p].size()), 0);
            chk("access queue drained", p, 32'(aq[p].size()), 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
